// File: rtl/aes_seq_pkg.sv
// Shared state enum, state-register select codes and round constants for the AES round sequencer.
// Build option AES_SEQ_FULL_IMC_EN: InvMixColumns covers all four columns in one cycle.
package aes_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_ARK0,
    ST_ISR,
    ST_ISB,
    ST_ARK,
    ST_IMC,
    ST_F_ISR,
    ST_F_ISB,
    ST_F_ARK,
    ST_DONE
  } seq_state_e;

  localparam logic [2:0] SEL_HOLD = 3'd0;
  localparam logic [2:0] SEL_LOAD = 3'd1;
  localparam logic [2:0] SEL_ISR  = 3'd2;
  localparam logic [2:0] SEL_ISB  = 3'd3;
  localparam logic [2:0] SEL_ARK  = 3'd4;
  localparam logic [2:0] SEL_IMC  = 3'd5;

  localparam int NUM_ROUNDS = 10;

`ifdef AES_SEQ_FULL_IMC_EN
  localparam int IMC_CYCLES = 1;
`else
  localparam int IMC_CYCLES = 4;
`endif

endpackage

// File: rtl/aes_seq_wait_counter.sv
// Loadable saturating down-counter with a zero flag; paces the key-expansion wait and IMC columns.
module aes_seq_wait_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM stepping the AES-128 inverse-cipher datapath: load, key wait, ARK0, 9 rounds, final round.
// Build option AES_SEQ_FULL_IMC_EN collapses InvMixColumns to one cycle with IMC_COL held at 0.
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int KEYEXP_WAIT = 12
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       BUSY,
  output logic [2:0] STATE_SEL,
  output logic [3:0] RK_IDX,
  output logic [1:0] IMC_COL,
  output logic [3:0] ROUND
);

  localparam logic [7:0] WAIT_LOAD = 8'(KEYEXP_WAIT - 1);
  localparam logic [7:0] IMC_LOAD  = 8'(IMC_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       cnt_load;
  logic [7:0] cnt_val;
  logic [7:0] cnt_count;
  logic       cnt_zero;

  aes_seq_wait_counter #(.WIDTH(8)) u_wait (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (1'b1),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    // Start dropping in any busy state aborts; the datapath simply holds.
    if (BUSY && !AES_START) begin
      state_d = ST_IDLE;
      round_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (AES_START) begin
            state_d  = ST_KEYEXP;
            cnt_load = 1'b1;
            cnt_val  = WAIT_LOAD;
          end
        end
        ST_KEYEXP: if (cnt_zero) state_d = ST_ARK0;
        ST_ARK0: begin
          state_d = ST_ISR;
          round_d = 4'd1;
        end
        ST_ISR:  state_d = ST_ISB;
        ST_ISB:  state_d = ST_ARK;
        ST_ARK: begin
          state_d  = ST_IMC;
          cnt_load = 1'b1;
          cnt_val  = IMC_LOAD;
        end
        ST_IMC: begin
          if (cnt_zero) begin
            round_d = round_q + 4'd1;
            state_d = (round_q == 4'(NUM_ROUNDS - 1)) ? ST_F_ISR : ST_ISR;
          end
        end
        ST_F_ISR: state_d = ST_F_ISB;
        ST_F_ISB: state_d = ST_F_ARK;
        ST_F_ARK: state_d = ST_DONE;
        ST_DONE: begin
          if (!AES_START) begin
            state_d = ST_IDLE;
            round_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign BUSY     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign AES_DONE = (state_q == ST_DONE);
  assign ROUND    = round_q;

  always_comb begin
    STATE_SEL = SEL_HOLD;
    RK_IDX    = '0;
    IMC_COL   = '0;
    case (state_q)
      // The counter sits at its load value only in the first KEYEXP cycle.
      ST_KEYEXP: if (cnt_count == WAIT_LOAD) STATE_SEL = SEL_LOAD;
      ST_ARK0, ST_ARK, ST_F_ARK: begin
        STATE_SEL = SEL_ARK;
        RK_IDX    = 4'(NUM_ROUNDS) - round_q;
      end
      ST_ISR, ST_F_ISR: STATE_SEL = SEL_ISR;
      ST_ISB, ST_F_ISB: STATE_SEL = SEL_ISB;
      ST_IMC: begin
        STATE_SEL = SEL_IMC;
`ifdef AES_SEQ_FULL_IMC_EN
        IMC_COL   = '0;
`else
        IMC_COL   = 2'(IMC_LOAD - cnt_count);
`endif
      end
      default: ;
    endcase
  end

endmodule
